// File: rtl/exec_stall_ctrl_pkg.sv
// Shared EXEC-core definitions: op classes, sequencer states and the
// opcode/funct values the core decoder uses to pick an op class.
package exec_stall_ctrl_pkg;

  typedef enum logic [2:0] {
    OPC_SINGLE = 3'd0,
    OPC_MEM,
    OPC_FDIV,
    OPC_FSQRT,
    OPC_IN,
    OPC_OUT
  } op_class_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_LAT,
    ST_WAIT_RX,
    ST_WAIT_TX
  } exec_state_t;

  localparam logic [6:0] OP_LW          = 7'b0000011;
  localparam logic [6:0] OP_LW_S        = 7'b0000111;
  localparam logic [6:0] OP_FPU         = 7'b1010011;
  localparam logic [6:0] OP_IN          = 7'b0001011;
  localparam logic [6:0] OP_OUT         = 7'b0101011;
  localparam logic [4:0] FPU_FUNCT_DIV  = 5'b00011;
  localparam logic [4:0] FPU_FUNCT_SQRT = 5'b01011;

  // Decoder helper: map an instruction's opcode/funct to its sequencing class
  function automatic op_class_t decode_op_class(input logic [6:0] opcode,
                                                input logic [4:0] funct);
    op_class_t c;
    c = OPC_SINGLE;
    if (opcode == OP_LW || opcode == OP_LW_S) c = OPC_MEM;
    else if (opcode == OP_FPU && funct == FPU_FUNCT_DIV) c = OPC_FDIV;
    else if (opcode == OP_FPU && funct == FPU_FUNCT_SQRT) c = OPC_FSQRT;
    else if (opcode == OP_IN) c = OPC_IN;
    else if (opcode == OP_OUT) c = OPC_OUT;
    return c;
  endfunction

endpackage

// File: rtl/exec_stall_ctrl_if.sv
// Core <-> stall controller signal bundle. The core is the master.
interface exec_stall_ctrl_if
  import exec_stall_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
);
  logic             exec;
  logic             flush;
  op_class_t        op_class;
  logic             rx_valid;
  logic             tx_ready;
  logic             advance;
  logic             wb_en;
  logic             tx_start;
  logic             busy;
  logic             err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output exec, flush, op_class, rx_valid, tx_ready,
    input  advance, wb_en, tx_start, busy, err, stall_cycles
  );

  modport slave (
    input  exec, flush, op_class, rx_valid, tx_ready,
    output advance, wb_en, tx_start, busy, err, stall_cycles
  );
endinterface

// File: rtl/exec_stall_ctrl_lat_counter.sv
// Loadable down-counter with zero flag; stops at zero.
module exec_stall_ctrl_lat_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);
  logic [W-1:0] r_cnt;

  // Clear beats load beats decrement
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         r_cnt <= '0;
    else if (i_clr)                  r_cnt <= '0;
    else if (i_load)                 r_cnt <= i_load_val;
    else if (i_dec && r_cnt != '0)   r_cnt <= r_cnt - W'(1);
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/exec_stall_ctrl.sv
// Sequences multi-cycle and UART-blocking ops for the single-issue EXEC core:
// decides when the PC may advance and when results commit; counts stalls.
module exec_stall_ctrl
  import exec_stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT   = 1,
  parameter int unsigned FDIV_LAT  = 3,
  parameter int unsigned FSQRT_LAT = 3,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             CLK,
  input  logic             RST,
  exec_stall_ctrl_if.slave bus
);
  localparam int unsigned MAX_A   = (MEM_LAT > FDIV_LAT) ? MEM_LAT : FDIV_LAT;
  localparam int unsigned MAX_LAT = (MAX_A > FSQRT_LAT) ? MAX_A : FSQRT_LAT;
  localparam int unsigned LAT_W   = (MAX_LAT > 0) ? $clog2(MAX_LAT + 1) : 1;

  exec_state_t      r_state, w_next_state;
  op_class_t        r_cls, w_next_cls;
  logic             r_err;
  logic [CNT_W-1:0] r_stall;

  logic             w_active, w_adv, w_wb, w_tx, w_err_set;
  logic             w_clr, w_load, w_dec, w_zero;
  logic [LAT_W-1:0] w_load_val;
  logic [31:0]      w_lat;

  function automatic logic [31:0] lat_of(input op_class_t c);
    case (c)
      OPC_MEM:   return 32'(MEM_LAT);
      OPC_FDIV:  return 32'(FDIV_LAT);
      OPC_FSQRT: return 32'(FSQRT_LAT);
      default:   return '0;
    endcase
  endfunction

  exec_stall_ctrl_lat_counter #(.W(LAT_W)) u_lat (
    .clk        (CLK),
    .rst        (RST),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  // Next state, counter control and same-cycle completion strobes
  always_comb begin
    w_next_state = r_state;
    w_next_cls   = r_cls;
    w_clr        = 1'b0;
    w_load       = 1'b0;
    w_dec        = 1'b0;
    w_adv        = 1'b0;
    w_wb         = 1'b0;
    w_tx         = 1'b0;
    w_lat        = lat_of(bus.op_class);
    w_load_val   = LAT_W'(w_lat - 32'd1);
    w_active     = bus.exec & ~bus.flush;
    w_err_set    = w_active && (r_state != ST_IDLE) && (bus.op_class != r_cls);

    if (!w_active) begin
      w_next_state = ST_IDLE;
      w_clr        = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_next_cls = bus.op_class;
          case (bus.op_class)
            OPC_MEM, OPC_FDIV, OPC_FSQRT: begin
              if (w_lat == '0) begin
                w_adv = 1'b1;
                w_wb  = 1'b1;
              end else begin
                w_load       = 1'b1;
                w_next_state = ST_WAIT_LAT;
              end
            end
            OPC_IN: begin
              if (bus.rx_valid) begin
                w_adv = 1'b1;
                w_wb  = 1'b1;
              end else begin
                w_next_state = ST_WAIT_RX;
              end
            end
            OPC_OUT: begin
              if (bus.tx_ready) begin
                w_adv = 1'b1;
                w_tx  = 1'b1;
              end else begin
                w_next_state = ST_WAIT_TX;
              end
            end
            default: begin
              w_adv = 1'b1;
              w_wb  = 1'b1;
            end
          endcase
        end
        ST_WAIT_LAT: begin
          if (w_zero) begin
            w_adv        = 1'b1;
            w_wb         = 1'b1;
            w_next_state = ST_IDLE;
          end else begin
            w_dec = 1'b1;
          end
        end
        ST_WAIT_RX: begin
          if (bus.rx_valid) begin
            w_adv        = 1'b1;
            w_wb         = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        ST_WAIT_TX: begin
          if (bus.tx_ready) begin
            w_adv        = 1'b1;
            w_tx         = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // State and latched op class
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cls   <= OPC_SINGLE;
    end else begin
      r_state <= w_next_state;
      r_cls   <= w_next_cls;
    end
  end

  // Sticky class-change error and saturating stall counter
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_err   <= 1'b0;
      r_stall <= '0;
    end else begin
      if (w_err_set) r_err <= 1'b1;
      if (w_active && !w_adv && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
    end
  end

  assign bus.advance      = w_adv;
  assign bus.wb_en        = w_wb;
  assign bus.tx_start     = w_tx;
  assign bus.busy         = (r_state != ST_IDLE);
  assign bus.err          = r_err;
  assign bus.stall_cycles = r_stall;
endmodule

// File: tb/tb_exec_stall_ctrl.sv
// Scoreboard bench for exec_stall_ctrl: a per-instruction reference model
// pushes expected per-cycle outputs; a negedge monitor pops and compares.
module tb_exec_stall_ctrl;
  import exec_stall_ctrl_pkg::*;

  localparam int unsigned MEM_LAT   = 1;
  localparam int unsigned FDIV_LAT  = 3;
  localparam int unsigned FSQRT_LAT = 3;

  typedef struct packed {
    logic        adv;
    logic        wb;
    logic        tx;
    logic        busy;
    logic        err;
    logic [31:0] stall;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  exec_stall_ctrl_if #(.CNT_W(32)) bus ();

  exec_stall_ctrl #(
    .MEM_LAT   (MEM_LAT),
    .FDIV_LAT  (FDIV_LAT),
    .FSQRT_LAT (FSQRT_LAT),
    .CNT_W     (32)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state: the instruction in flight and cycles since issue
  logic        m_busy  = 1'b0;
  op_class_t   m_kind  = OPC_SINGLE;
  int          m_el    = 0;
  logic        m_err   = 1'b0;
  logic [31:0] m_stall = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat(input op_class_t k);
    case (k)
      OPC_MEM:   return MEM_LAT;
      OPC_FDIV:  return FDIV_LAT;
      OPC_FSQRT: return FSQRT_LAT;
      default:   return 0;
    endcase
  endfunction

  task automatic model_step(input logic e, input logic f, input op_class_t op,
                            input logic rx, input logic tx);
    exp_t      x;
    op_class_t k;
    int        el;
    logic      done;
    x.busy = m_busy; x.err = m_err; x.stall = m_stall;
    x.adv = 1'b0; x.wb = 1'b0; x.tx = 1'b0;
    if (!e || f) begin
      m_busy = 1'b0;
    end else begin
      if (m_busy && op != m_kind) m_err = 1'b1;
      k  = m_busy ? m_kind : op;
      el = m_busy ? m_el + 1 : 0;
      case (k)
        OPC_MEM, OPC_FDIV, OPC_FSQRT: done = (el >= lat(k));
        OPC_IN:  done = rx;
        OPC_OUT: done = tx;
        default: done = 1'b1;
      endcase
      if (done) begin
        x.adv  = 1'b1;
        x.wb   = (k != OPC_OUT);
        x.tx   = (k == OPC_OUT);
        m_busy = 1'b0;
      end else begin
        m_busy = 1'b1;
        m_kind = k;
        m_el   = el;
        if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 32'd1;
      end
    end
    exp_q.push_back(x);
  endtask

  // Called just after a posedge: drive, predict, then advance one clock
  task automatic cycle(input logic e, input logic f, input op_class_t op,
                       input logic rx, input logic tx);
    bus.exec = e; bus.flush = f; bus.op_class = op;
    bus.rx_valid = rx; bus.tx_ready = tx;
    model_step(e, f, op, rx, tx);
    @(posedge CLK);
    #1;
  endtask

  // Monitor: compare every predicted cycle at the falling edge
  always @(negedge CLK) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("advance",      32'(bus.advance),  32'(e.adv));
      check("wb_en",        32'(bus.wb_en),    32'(e.wb));
      check("tx_start",     32'(bus.tx_start), 32'(e.tx));
      check("busy",         32'(bus.busy),     32'(e.busy));
      check("err",          32'(bus.err),      32'(e.err));
      check("stall_cycles", bus.stall_cycles,  e.stall);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    op_class_t cur;
    logic      need_new;
    logic      e, f, rx, tx;

    bus.exec = 1'b0; bus.flush = 1'b0; bus.op_class = OPC_SINGLE;
    bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
    @(posedge CLK); @(posedge CLK); #1;
    check("rst_advance", 32'(bus.advance), 32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_err",     32'(bus.err),     32'd0);
    check("rst_stall",   bus.stall_cycles, 32'd0);
    RST = 1'b0;

    // SINGLE x3
    repeat (3) cycle(1, 0, OPC_SINGLE, 0, 0);
    // MEM then FDIV
    repeat (2) cycle(1, 0, OPC_MEM, 0, 0);
    repeat (4) cycle(1, 0, OPC_FDIV, 0, 0);
    // Two back-to-back FDIV
    repeat (8) cycle(1, 0, OPC_FDIV, 0, 0);
    // IN waits for rx_valid, then IN with immediate rx_valid
    repeat (6) cycle(1, 0, OPC_IN, 0, 0);
    cycle(1, 0, OPC_IN, 1, 0);
    cycle(1, 0, OPC_IN, 1, 0);
    // OUT waits for tx_ready
    repeat (4) cycle(1, 0, OPC_OUT, 0, 0);
    cycle(1, 0, OPC_OUT, 0, 1);
    // FSQRT flushed on its completion cycle, then SINGLE
    repeat (3) cycle(1, 0, OPC_FSQRT, 0, 0);
    cycle(1, 1, OPC_FSQRT, 0, 0);
    cycle(1, 0, OPC_SINGLE, 0, 0);
    // exec dropped mid-FDIV
    repeat (2) cycle(1, 0, OPC_FDIV, 0, 0);
    cycle(0, 0, OPC_FDIV, 0, 0);

    // Randomised instruction stream with the core holding op_class while stalled
    need_new = 1'b1;
    cur      = OPC_SINGLE;
    for (int i = 0; i < 1500; i++) begin
      e  = ($urandom_range(0, 19) != 0);
      f  = ($urandom_range(0, 19) == 0);
      rx = ($urandom_range(0, 3) == 0);
      tx = ($urandom_range(0, 2) == 0);
      if (need_new) cur = op_class_t'($urandom_range(0, 5));
      cycle(e, f, cur, rx, tx);
      need_new = !m_busy;
    end
    cycle(0, 0, OPC_SINGLE, 0, 0);

    // op_class changes under an in-flight FDIV
    cycle(1, 0, OPC_FDIV, 0, 0);
    repeat (3) cycle(1, 0, OPC_SINGLE, 0, 0);
    cycle(1, 0, OPC_SINGLE, 0, 0);

    // Asynchronous reset in the middle of an FDIV
    repeat (2) cycle(1, 0, OPC_FDIV, 0, 0);
    @(negedge CLK); #1;
    RST = 1'b1;
    m_busy = 1'b0; m_err = 1'b0; m_stall = '0;
    #1;
    check("arst_busy",    32'(bus.busy),     32'd0);
    check("arst_err",     32'(bus.err),      32'd0);
    check("arst_stall",   bus.stall_cycles,  32'd0);
    check("arst_advance", 32'(bus.advance),  32'd0);
    check("arst_wb_en",   32'(bus.wb_en),    32'd0);
    bus.exec = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    repeat (2) cycle(1, 0, OPC_SINGLE, 0, 0);
    repeat (2) cycle(1, 0, OPC_MEM, 0, 0);

    for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(negedge CLK);
    #1;
    if (exp_q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
